alu_commit_arbiter: RTL and testbench
=====================================

# alu_commit_arbiter

Shares the single register-file write port among `N_SRC` ALU result channels. Each ALU (alu0 and its siblings) presents a registered result with `valid`. The arbiter grants one source per cycle and pulses that ALU's `clear` so it drops its result. It then holds the winning result in a one-entry output register until the register file accepts it. It sits between the ALU bank and the commit/writeback stage, and routes ALU error results to the exception path instead of the register file.

## Interface
- `N_SRC`, 4: number of ALU result channels (2..8).
- `XLEN`, `core_config_pkg::XLEN`: result width.
- `REG_ADDR_W`, `core_config_pkg::REG_ADDR_W`: destination register index width.

- `clk`  in  1  single core clock; one clock domain, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  `N_SRC`  per-ALU result valid.
- `src_res`  in  `N_SRC`×`XLEN`  per-ALU result.
- `src_rd`  in  `N_SRC`×`REG_ADDR_W`  per-ALU destination register.
- `src_error`  in  `N_SRC`  per-ALU result error flag.
- `src_clear`  out  `N_SRC`  one-hot combinational grant; tells the ALU its result is consumed.
- `flush`  in  1  pipeline flush.
- `wb_valid`  out  1  write request to the register file.
- `wb_data`  out  `XLEN`  write data.
- `wb_rd`  out  `REG_ADDR_W`  write address.
- `wb_ready`  in  1  register file accepts the write this cycle.
- `exc_valid`  out  1  one-cycle pulse: an error result was consumed.
- `exc_src`  out  `$clog2(N_SRC)`  index of the erroring source.

## Operation
- Slot free this cycle = `!wb_valid || wb_ready`.
- Grant rule:
  - Only when slot free, `!flush`, and any `src_valid` is high.
  - Round-robin search starts at `rr_ptr` and wraps from `N_SRC-1` to 0.
  - `src_clear[g]` is high in the grant cycle only.
- On grant of source `g`, at the next edge:
  - `src_error[g]=1`: `exc_valid<=1`, `exc_src<=g`, `wb_valid<=0` (data discarded).
  - else `src_rd[g]==0`: result discarded, `wb_valid<=0`, no exception.
  - else `wb_valid<=1`, `wb_data<=src_res[g]`, `wb_rd<=src_rd[g]`.
  - `rr_ptr<=(g+1) mod N_SRC`.
- No grant and `wb_ready` high: `wb_valid<=0`.
- `wb_valid` high and `wb_ready` low: `wb_data` and `wb_rd` are held stable.
- `exc_valid` is never high for more than one cycle unless consecutive grants are errors.
- `flush` high:
  - `src_clear` = `src_valid`, clearing all pending ALU results.
  - Next edge: `wb_valid<=0`, `exc_valid<=0`; `rr_ptr` unchanged.
  - No grant occurs in a flush cycle.
- Reset values (async, immediate):
  - `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `exc_valid`=0, `exc_src`=0, `rr_ptr`=0.
  - `src_clear` forced 0 while `rst_n` is low.
  - Reset mid-transfer drops the buffered result.

## Timing
- Latency: source valid at cycle t with slot free → `src_clear` in cycle t → `wb_valid` in cycle t+1.
- Throughput: one result per cycle while `wb_ready` is held high.
- Grant in cycle t and `wb_ready` in cycle t handled together: old entry retires and new entry loads at the same edge.
- ALUs must drop `src_valid` in the cycle after `src_clear`. The arbiter relies on this; it never re-grants the same source in consecutive cycles unless `src_valid` is re-asserted.
- `src_clear` is combinational from `src_valid`, `wb_valid`, `wb_ready`, `flush` and `rr_ptr`. There is no path from `src_res`.

## Configuration
- `ALU_COMMIT_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. `rr_ptr` is not implemented and is treated as constant 0.
- Undefined (default): round-robin as above.
- All other behaviour is identical.

## Structure
- `core_config_pkg` gains `N_ALU_SRC` (default value for `N_SRC`).
- `core_config_pkg` gains `commit_entry_t` (`data`, `rd`, `err`), used for the output register.
- One sub-module: `rr_arbiter`.
  - Parameter `N`; inputs `req[N]`, `ptr`, `en`; outputs one-hot `gnt[N]`, `gnt_idx`.
  - Purely combinational.
  - The macro selects the masked-rotate path versus plain priority encoding inside it.

## Test plan
- Reset, then `src_valid[2]=1`, `src_res[2]=32'h0000_00AA`, `src_rd[2]=5`, `wb_ready=1`:
  - `src_clear=4'b0100` in cycle 0.
  - Cycle 1: `wb_valid=1`, `wb_data=32'hAA`, `wb_rd=5`.
- All four valid every cycle, `wb_ready=1`:
  - Grants 0,1,2,3,0 on consecutive cycles.
  - With `ALU_COMMIT_ARB_FIXED_PRIO_EN`: grants 0 every cycle.
- `wb_ready=0` for 3 cycles with an entry buffered and `src_valid[1]=1`:
  - `wb_data`/`wb_rd` stable and `src_clear=0` throughout.
  - On the `wb_ready=1` cycle, `src_clear=4'b0010`; next cycle `wb_data=src_res[1]`.
- `src_valid[3]=1`, `src_error[3]=1`:
  - `src_clear[3]` pulses.
  - Next cycle `exc_valid=1`, `exc_src=3`, `wb_valid=0`.
- `src_rd[0]=0` with valid: `src_clear[0]` pulses; `wb_valid` and `exc_valid` stay 0.
- `flush=1` with `wb_valid=1`, `wb_ready=0`, `src_valid=4'b1010`:
  - `src_clear=4'b1010` in the flush cycle.
  - Next cycle `wb_valid=0`; `rr_ptr` unchanged.
  - Asserting `rst_n=0` mid-stall clears all outputs immediately.

Source files
------------

// File: rtl/core_config_pkg.sv
// core_config_pkg: core-wide configuration shared by the ALU commit path.
//   XLEN        result / register width
//   REG_ADDR_W  register-file index width
//   N_ALU_SRC   default number of ALU result channels feeding the commit arbiter
//   commit_entry_t  one buffered commit: data, destination rd, error flag
package core_config_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int N_ALU_SRC  = 4;

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  err;
  } commit_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational one-hot arbiter.
// Ports:
//   i_req      request vector, one bit per requester
//   i_ptr      index where the round-robin search starts
//   i_en       arbitration enable; no grant when low
//   o_gnt      one-hot grant
//   o_gnt_idx  binary index of the granted requester
// Macro ALU_COMMIT_ARB_FIXED_PRIO_EN: plain priority encoder (lowest index
// wins, i_ptr ignored). Default: masked-rotate round robin starting at i_ptr.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic w_found;

`ifdef ALU_COMMIT_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins.
  always_comb begin
    w_found   = 1'b0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    if (i_en) begin
      for (int i = 0; i < N; i++) begin
        if (i_req[i] && !w_found) begin
          w_found   = 1'b1;
          o_gnt[i]  = 1'b1;
          o_gnt_idx = IDX_W'(i);
        end
      end
    end
  end
`else
  logic [N-1:0] w_masked;

  // Requests at or above the pointer get first pick; if none exist the
  // search wraps to the unmasked vector, which yields lowest index overall.
  always_comb begin
    w_masked  = '0;
    w_found   = 1'b0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_masked[i] = i_req[i] && (i >= int'(i_ptr));
    end
    if (i_en) begin
      for (int i = 0; i < N; i++) begin
        if (w_masked[i] && !w_found) begin
          w_found   = 1'b1;
          o_gnt[i]  = 1'b1;
          o_gnt_idx = IDX_W'(i);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (i_req[i] && !w_found) begin
          w_found   = 1'b1;
          o_gnt[i]  = 1'b1;
          o_gnt_idx = IDX_W'(i);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/alu_commit_arbiter.sv
// alu_commit_arbiter: shares the single register-file write port among
// N_SRC ALU result channels, with a one-entry output register.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_src_valid/res/rd/error  per-ALU result (flattened, source 0 in LSBs)
//   o_src_clear       one-hot grant; tells the ALU its result was consumed
//   i_flush           drops every pending ALU result and the buffered entry
//   o_wb_valid/data/rd, i_wb_ready  write request to the register file
//   o_exc_valid, o_exc_src  one-cycle pulse when an error result is consumed
// Macro ALU_COMMIT_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins),
// no round-robin pointer. Default: round robin.
module alu_commit_arbiter
  import core_config_pkg::*;
#(
  parameter int N_SRC      = core_config_pkg::N_ALU_SRC,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SRC-1:0]            i_src_valid,
  input  logic [N_SRC*XLEN-1:0]       i_src_res,
  input  logic [N_SRC*REG_ADDR_W-1:0] i_src_rd,
  input  logic [N_SRC-1:0]            i_src_error,
  output logic [N_SRC-1:0]            o_src_clear,
  input  logic                        i_flush,
  output logic                        o_wb_valid,
  output logic [XLEN-1:0]             o_wb_data,
  output logic [REG_ADDR_W-1:0]       o_wb_rd,
  input  logic                        i_wb_ready,
  output logic                        o_exc_valid,
  output logic [$clog2(N_SRC)-1:0]    o_exc_src
);

  localparam int IDX_W = $clog2(N_SRC);

  logic                  r_wb_valid;
  commit_entry_t         r_entry;
  logic [IDX_W-1:0]      r_exc_src;
  logic [IDX_W-1:0]      w_rr_ptr;
  logic                  w_slot_free;
  logic                  w_arb_en;
  logic [N_SRC-1:0]      w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_grant;
  logic [XLEN-1:0]       w_sel_res;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic                  w_sel_err;
  logic [IDX_W-1:0]      w_next_ptr;

  // The slot can take a new entry when empty or when the current one retires
  // at this same edge.
  assign w_slot_free = !r_wb_valid || i_wb_ready;
  assign w_arb_en    = w_slot_free && !i_flush;

  rr_arbiter #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req     (i_src_valid),
    .i_ptr     (w_rr_ptr),
    .i_en      (w_arb_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_grant    = |w_gnt;
  assign w_sel_res  = i_src_res[int'(w_gnt_idx)*XLEN +: XLEN];
  assign w_sel_rd   = i_src_rd[int'(w_gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign w_sel_err  = i_src_error[w_gnt_idx];
  assign w_next_ptr = (w_gnt_idx == IDX_W'(N_SRC-1)) ? '0 : w_gnt_idx + 1'b1;

  // Flush clears every pending ALU result; held at zero during reset so the
  // ALUs never see a consume while the arbiter is not running.
  assign o_src_clear = !rst_n  ? '0 :
                       i_flush ? i_src_valid : w_gnt;

`ifdef ALU_COMMIT_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [IDX_W-1:0] r_rr_ptr;

  // Pointer moves just past the winner; flush leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  // Output register. r_entry.err doubles as the one-cycle exception pulse;
  // error and rd==0 results are consumed without touching the held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_entry    <= '0;
      r_exc_src  <= '0;
    end else if (i_flush) begin
      r_wb_valid  <= 1'b0;
      r_entry.err <= 1'b0;
    end else if (w_grant) begin
      r_entry.err <= w_sel_err;
      if (w_sel_err) begin
        r_exc_src <= w_gnt_idx;
      end
      if (!w_sel_err && (w_sel_rd != '0)) begin
        r_wb_valid   <= 1'b1;
        r_entry.data <= w_sel_res;
        r_entry.rd   <= w_sel_rd;
      end else begin
        r_wb_valid <= 1'b0;
      end
    end else begin
      r_entry.err <= 1'b0;
      if (i_wb_ready) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  assign o_wb_valid  = r_wb_valid;
  assign o_wb_data   = r_entry.data;
  assign o_wb_rd     = r_entry.rd;
  assign o_exc_valid = r_entry.err;
  assign o_exc_src   = r_exc_src;

endmodule

// File: tb/tb_alu_commit_arbiter.sv
// tb_alu_commit_arbiter: directed and randomized checking of
// alu_commit_arbiter against a reference model held in the bench.
// Honours macro ALU_COMMIT_ARB_FIXED_PRIO_EN the same way as the design.
module tb_alu_commit_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int RW = 5;

  typedef struct {
    logic [XL-1:0] data;
    logic [RW-1:0] rd;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    i_src_valid = '0;
  logic [N*XL-1:0] i_src_res = '0;
  logic [N*RW-1:0] i_src_rd = '0;
  logic [N-1:0]    i_src_error = '0;
  logic [N-1:0]    o_src_clear;
  logic            i_flush = 1'b0;
  logic            o_wb_valid;
  logic [XL-1:0]   o_wb_data;
  logic [RW-1:0]   o_wb_rd;
  logic            i_wb_ready = 1'b0;
  logic            o_exc_valid;
  logic [1:0]      o_exc_src;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int       mPtr = 0;
  bit       mWbv = 0;
  bit       mExc = 0;
  bit       mDrop = 0;
  wr_t      wq[$];
  int       eq[$];
  logic [N-1:0] expClear;

  // Stimulus values for the ALU sources
  logic [XL-1:0] bRes[N];
  logic [RW-1:0] bRd[N];

  alu_commit_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_src_valid (i_src_valid),
    .i_src_res   (i_src_res),
    .i_src_rd    (i_src_rd),
    .i_src_error (i_src_error),
    .o_src_clear (o_src_clear),
    .i_flush     (i_flush),
    .o_wb_valid  (o_wb_valid),
    .o_wb_data   (o_wb_data),
    .o_wb_rd     (o_wb_rd),
    .i_wb_ready  (i_wb_ready),
    .o_exc_valid (o_exc_valid),
    .o_exc_src   (o_exc_src)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    mPtr = 0;
    mWbv = 0;
    mExc = 0;
    mDrop = 0;
    wq.delete();
    eq.delete();
  endtask

  // One clock of stimulus: verify registered outputs against the model,
  // drive inputs, check the combinational grant, then advance the model.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] err,
                               input logic fl, input logic rdy);
    int g;
    wr_t w;
    @(negedge clk);
    if (mDrop) begin
      void'(wq.pop_back());
      mDrop = 0;
    end
    checkOutput("wb_valid", o_wb_valid, mWbv);
    checkOutput("exc_valid", o_exc_valid, mExc);
    i_src_valid = v;
    i_src_error = err;
    for (int i = 0; i < N; i++) begin
      i_src_res[i*XL +: XL] = bRes[i];
      i_src_rd[i*RW +: RW]  = bRd[i];
    end
    i_flush = fl;
    i_wb_ready = rdy;
    #1;
    if (fl) begin
      expClear = v;
      if (mWbv && !rdy) mDrop = 1;
      mWbv = 0;
      mExc = 0;
    end else if ((!mWbv || rdy) && (v != 0)) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(mPtr + k) % N]) g = (mPtr + k) % N;
      end
      expClear = N'(1) << g;
      if (err[g]) begin
        mExc = 1;
        mWbv = 0;
        eq.push_back(g);
      end else if (bRd[g] == 0) begin
        mExc = 0;
        mWbv = 0;
      end else begin
        mExc = 0;
        mWbv = 1;
        w.data = bRes[g];
        w.rd = bRd[g];
        wq.push_back(w);
      end
`ifndef ALU_COMMIT_ARB_FIXED_PRIO_EN
      mPtr = (g + 1) % N;
`endif
    end else begin
      expClear = '0;
      mExc = 0;
      if (rdy) mWbv = 0;
    end
    checkOutput("src_clear", o_src_clear, expClear);
  endtask

  // Monitor: whenever the DUT presents a write or an exception, compare it
  // with the head of the matching scoreboard queue.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && o_wb_valid) begin
      if (wq.size() == 0) begin
        checkOutput("wb_unexpected", 64'd1, 64'd0);
      end else begin
        checkOutput("wb_data", o_wb_data, wq[0].data);
        checkOutput("wb_rd", o_wb_rd, wq[0].rd);
        if (i_wb_ready) void'(wq.pop_front());
      end
    end
    if (rst_n && o_exc_valid) begin
      if (eq.size() == 0) begin
        checkOutput("exc_unexpected", 64'd1, 64'd0);
      end else begin
        checkOutput("exc_src", o_exc_src, eq.pop_front());
      end
    end
  end

  task automatic checkResetOutputs();
    checkOutput("rst_wb_valid", o_wb_valid, 0);
    checkOutput("rst_wb_data", o_wb_data, 0);
    checkOutput("rst_wb_rd", o_wb_rd, 0);
    checkOutput("rst_exc_valid", o_exc_valid, 0);
    checkOutput("rst_exc_src", o_exc_src, 0);
    checkOutput("rst_src_clear", o_src_clear, 0);
  endtask

  // Random-phase ALU model: each source holds a result until cleared and
  // stays idle for one cycle after a clear.
  bit           pend[N];
  bit           cool[N];
  logic [N-1:0] rErr;

  initial begin
    for (int i = 0; i < N; i++) begin
      bRes[i] = '0;
      bRd[i] = '0;
      pend[i] = 0;
      cool[i] = 0;
    end
    rErr = '0;

    // Reset state
    clearModel();
    #1;
    checkResetOutputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single result from source 2
    bRes[2] = 32'h0000_00AA;
    bRd[2] = 5;
    applyStimulus(4'b0100, 4'b0000, 0, 1);
    applyStimulus(4'b0000, 4'b0000, 0, 1);

    // All four valid every cycle
    for (int i = 0; i < N; i++) begin
      bRes[i] = 32'h1000 + i;
      bRd[i] = RW'(i + 1);
    end
    repeat (5) applyStimulus(4'b1111, 4'b0000, 0, 1);

    // Stall with source 1 waiting, then release
    applyStimulus(4'b0010, 4'b0000, 0, 0);
    applyStimulus(4'b0010, 4'b0000, 0, 0);
    applyStimulus(4'b0010, 4'b0000, 0, 0);
    bRes[1] = 32'hDEAD_BEEF;
    applyStimulus(4'b0010, 4'b0000, 0, 1);
    applyStimulus(4'b0000, 4'b0000, 0, 1);

    // Error result from source 3
    applyStimulus(4'b1000, 4'b1000, 0, 1);
    applyStimulus(4'b0000, 4'b0000, 0, 1);

    // rd == 0 is discarded silently
    bRd[0] = 0;
    applyStimulus(4'b0001, 4'b0000, 0, 1);
    applyStimulus(4'b0000, 4'b0000, 0, 1);
    bRd[0] = 7;

    // Flush while an entry is stalled
    applyStimulus(4'b0100, 4'b0000, 0, 1);
    applyStimulus(4'b0000, 4'b0000, 0, 0);
    applyStimulus(4'b1010, 4'b0000, 1, 0);
    applyStimulus(4'b1010, 4'b0000, 0, 1);
    applyStimulus(4'b0000, 4'b0000, 0, 1);

    // Reset in the middle of a stall
    applyStimulus(4'b0001, 4'b0000, 0, 0);
    applyStimulus(4'b1010, 4'b0000, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    clearModel();
    @(negedge clk);
    i_src_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && !cool[i] && $urandom_range(0, 99) < 40) begin
          pend[i] = 1;
          bRes[i] = $urandom;
          bRd[i] = ($urandom_range(0, 9) == 0) ? RW'(0) : RW'($urandom_range(1, 31));
          rErr[i] = ($urandom_range(0, 9) == 0);
        end
        v[i] = pend[i];
      end
      applyStimulus(v, rErr & v, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) < 70));
      for (int i = 0; i < N; i++) begin
        cool[i] = expClear[i];
        if (expClear[i]) pend[i] = 0;
      end
    end

    // Drain and confirm every expected response was observed
    repeat (4) applyStimulus(4'b0000, 4'b0000, 0, 1);
    @(negedge clk);
    #5;
    checkOutput("wq_drained", wq.size(), 0);
    checkOutput("eq_drained", eq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
